// File: rtl/usb_transaction_controller.sv
// USB endpoint transaction sequencer: reacts to decoded RX tokens, launches TX
// packets from the software TX-control register and abandons stalled handshakes.
module usb_transaction_controller #(
   parameter int unsigned TIMEOUT_CYC = 255,
   parameter int unsigned OCC_W       = 7
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic [2:0]       rx_packet,
   input  logic             rx_data_ready,
   input  logic             rx_error,
   input  logic             tx_transfer_active,
   input  logic             tx_error,
   input  logic [OCC_W-1:0] buffer_occupancy,
   input  logic [1:0]       tx_ctrl,
   output logic [1:0]       tx_packet,
   output logic             tx_start,
   output logic             clear_tx_control,
   output logic             d_mode,
   output logic             xfer_done,
   output logic             timeout,
   output logic             xfer_err,
   output logic [2:0]       ctrl_state
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

   localparam logic [2:0] RX_DATA = 3'd0;
   localparam logic [2:0] RX_IN   = 3'd1;
   localparam logic [2:0] RX_OUT  = 3'd2;
   localparam logic [2:0] RX_ACK  = 3'd3;

   localparam logic [1:0] TXC_NONE = 2'd0;
   localparam logic [1:0] TXC_DATA = 2'd1;
   localparam logic [1:0] TXC_NAK  = 2'd3;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      IN_WAIT  = 3'd1,
      TX_SEND  = 3'd2,
      TX_BUSY  = 3'd3,
      WAIT_ACK = 3'd4,
      OUT_DATA = 3'd5
   } state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [1:0]       pid, pid_nxt;
   logic             seen_active, seen_nxt;
   logic             start_nxt, done_nxt, timeout_nxt, err_nxt;
   logic             cnt_expired;
   logic             tx_owned_nxt;

   assign cnt_expired  = (cnt == CNT_W'(TIMEOUT_CYC - 1));
   assign tx_owned_nxt = (state_nxt == TX_SEND) || (state_nxt == TX_BUSY);
   assign ctrl_state   = state;

   // Next-state and pulse decode; an arriving packet always beats timeout expiry.
   always_comb begin
      state_nxt   = state;
      pid_nxt     = pid;
      seen_nxt    = seen_active;
      start_nxt   = 1'b0;
      done_nxt    = 1'b0;
      timeout_nxt = 1'b0;
      err_nxt     = 1'b0;
      cnt_nxt     = cnt;

      case (state)
         IDLE: begin
            if (rx_data_ready && rx_packet == RX_IN) begin
               state_nxt = IN_WAIT;
            end else if (rx_data_ready && rx_packet == RX_OUT) begin
               state_nxt = OUT_DATA;
            end
         end
         IN_WAIT: begin
            if (tx_ctrl != TXC_NONE) begin
               state_nxt = TX_SEND;
               start_nxt = 1'b1;
               // Nothing buffered to send: answer the IN with NAK instead of DATA.
               pid_nxt   = (tx_ctrl == TXC_DATA && buffer_occupancy == '0) ? TXC_NAK : tx_ctrl;
            end else if (cnt_expired) begin
               state_nxt   = IDLE;
               timeout_nxt = 1'b1;
            end
         end
         TX_SEND: begin
            state_nxt = TX_BUSY;
            seen_nxt  = 1'b0;
         end
         TX_BUSY: begin
            if (tx_transfer_active) begin
               seen_nxt = 1'b1;
            end
            if (tx_error) begin
               state_nxt = IDLE;
               err_nxt   = 1'b1;
            end else if (seen_active && !tx_transfer_active) begin
               if (pid == TXC_DATA) begin
                  state_nxt = WAIT_ACK;
               end else begin
                  state_nxt = IDLE;
                  done_nxt  = 1'b1;
               end
            end
         end
         WAIT_ACK: begin
            if (rx_data_ready) begin
               state_nxt = IDLE;
               done_nxt  = (rx_packet == RX_ACK);
               err_nxt   = (rx_packet != RX_ACK);
            end else if (cnt_expired) begin
               state_nxt   = IDLE;
               timeout_nxt = 1'b1;
            end
         end
         OUT_DATA: begin
            if (rx_data_ready) begin
               state_nxt = IDLE;
               done_nxt  = (rx_packet == RX_DATA) && !rx_error;
               err_nxt   = (rx_packet != RX_DATA) || rx_error;
            end else if (cnt_expired) begin
               state_nxt   = IDLE;
               timeout_nxt = 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      if (state_nxt != state) begin
         cnt_nxt = '0;
      end else if ((state == IN_WAIT || state == WAIT_ACK || state == OUT_DATA) && cnt != '1) begin
         cnt_nxt = cnt + CNT_W'(1);
      end
   end

   // State, counter and registered outputs.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state            <= IDLE;
         cnt              <= '0;
         pid              <= TXC_NONE;
         seen_active      <= 1'b0;
         tx_packet        <= TXC_NONE;
         tx_start         <= 1'b0;
         clear_tx_control <= 1'b0;
         d_mode           <= 1'b0;
         xfer_done        <= 1'b0;
         timeout          <= 1'b0;
         xfer_err         <= 1'b0;
      end else begin
         state            <= state_nxt;
         cnt              <= cnt_nxt;
         pid              <= pid_nxt;
         seen_active      <= seen_nxt;
         tx_packet        <= tx_owned_nxt ? pid_nxt : TXC_NONE;
         tx_start         <= start_nxt;
         clear_tx_control <= start_nxt;
         d_mode           <= tx_owned_nxt;
         xfer_done        <= done_nxt;
         timeout          <= timeout_nxt;
         xfer_err         <= err_nxt;
      end
   end

endmodule

// File: tb/tb_usb_transaction_controller.sv
// Randomized scoreboard bench for usb_transaction_controller; expected pulses are
// queued by the stimulus and popped by an independent monitor.
module tb_usb_transaction_controller;

   localparam int TO    = 4;
   localparam int OCC_W = 7;

   localparam int K_START = 1;
   localparam int K_DONE  = 2;
   localparam int K_TOUT  = 4;
   localparam int K_ERR   = 8;

   typedef struct {
      int kind;
      int pid;
      int cyc;
   } ev_t;

   logic             clk = 1'b0;
   logic             n_rst = 1'b0;
   logic [2:0]       rx_packet = '0;
   logic             rx_data_ready = 1'b0;
   logic             rx_error = 1'b0;
   logic             tx_transfer_active = 1'b0;
   logic             tx_error = 1'b0;
   logic [OCC_W-1:0] buffer_occupancy = 7'd8;
   logic [1:0]       tx_ctrl = '0;
   logic [1:0]       tx_packet;
   logic             tx_start;
   logic             clear_tx_control;
   logic             d_mode;
   logic             xfer_done;
   logic             timeout;
   logic             xfer_err;
   logic [2:0]       ctrl_state;

   int  nchk = 0;
   int  nerr = 0;
   int  cyc  = 0;
   ev_t exp_q[$];

   usb_transaction_controller #(.TIMEOUT_CYC(TO), .OCC_W(OCC_W)) dut (
      .clk(clk), .n_rst(n_rst), .rx_packet(rx_packet), .rx_data_ready(rx_data_ready),
      .rx_error(rx_error), .tx_transfer_active(tx_transfer_active), .tx_error(tx_error),
      .buffer_occupancy(buffer_occupancy), .tx_ctrl(tx_ctrl), .tx_packet(tx_packet),
      .tx_start(tx_start), .clear_tx_control(clear_tx_control), .d_mode(d_mode),
      .xfer_done(xfer_done), .timeout(timeout), .xfer_err(xfer_err), .ctrl_state(ctrl_state)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int got, input int exp);
      nchk++;
      if (got != exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic push(input int kind, input int pid, input int at);
      ev_t e;
      e.kind = kind;
      e.pid  = pid;
      e.cyc  = at;
      exp_q.push_back(e);
   endtask

   // Monitor: every pulse must match the head of the expectation queue.
   always @(negedge clk) begin
      logic [3:0] got;
      ev_t        e;
      got = {xfer_err, timeout, xfer_done, tx_start};
      if (got != 4'd0) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_pulse", int'(got), 0);
         end else begin
            e = exp_q.pop_front();
            chk("pulse_kind", int'(got), e.kind);
            chk("pulse_cycle", cyc, e.cyc);
            if (e.kind == K_START) begin
               chk("tx_packet", int'(tx_packet), e.pid);
               chk("clear_tx_control", int'(clear_tx_control), 1);
               chk("d_mode_tx", int'(d_mode), 1);
            end else begin
               chk("end_state", int'(ctrl_state), 0);
               chk("end_d_mode", int'(d_mode), 0);
               chk("end_tx_packet", int'(tx_packet), 0);
            end
         end
      end
   end

   task automatic wait_cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_rx(input logic [2:0] pid, input logic err);
      rx_packet     = pid;
      rx_error      = err;
      rx_data_ready = 1'b1;
      wait_cyc(1);
      rx_data_ready = 1'b0;
      rx_error      = 1'b0;
      rx_packet     = '0;
   endtask

   // IN transaction: software answers after j cycles (ctrl 0 = never), TX runs len
   // cycles, then the host replies after k cycles with resp when DATA was sent.
   task automatic in_xact(input int j, input int ctrl, input int occ, input int len,
                          input bit txerr, input int k, input logic [2:0] resp);
      int t_in, t_s, t_c, pid;
      send_rx(3'd1, 1'b0);
      t_in = cyc;
      if (ctrl == 0 || j >= TO) begin
         push(K_TOUT, 0, t_in + TO);
         wait_cyc(TO + 1);
         if (ctrl != 0) begin
            tx_ctrl = 2'(ctrl);
            wait_cyc(2);
            chk("idle_ignores_ctrl_state", int'(ctrl_state), 0);
            chk("idle_ignores_ctrl_clear", int'(clear_tx_control), 0);
            tx_ctrl = '0;
         end
      end else begin
         wait_cyc(j);
         tx_ctrl          = 2'(ctrl);
         buffer_occupancy = OCC_W'(occ);
         wait_cyc(1);
         t_s     = cyc;
         tx_ctrl = '0;
         pid     = (ctrl == 1 && occ == 0) ? 3 : ctrl;
         push(K_START, pid, t_s);
         wait_cyc(1);
         tx_transfer_active = 1'b1;
         wait_cyc(len);
         tx_transfer_active = 1'b0;
         tx_error           = txerr;
         wait_cyc(1);
         tx_error = 1'b0;
         t_c      = cyc;
         if (txerr) begin
            push(K_ERR, 0, t_c);
         end else if (pid != 1) begin
            push(K_DONE, 0, t_c);
         end else if (k >= TO) begin
            push(K_TOUT, 0, t_c + TO);
            wait_cyc(TO + 1);
         end else begin
            wait_cyc(k);
            send_rx(resp, 1'b0);
            push((resp == 3'd3) ? K_DONE : K_ERR, 0, cyc);
         end
      end
      wait_cyc(2);
   endtask

   // OUT transaction: data packet pid (with err) arrives k cycles after the token.
   task automatic out_xact(input int k, input logic [2:0] pid, input bit err);
      int t_o;
      send_rx(3'd2, 1'b0);
      t_o = cyc;
      if (k >= TO) begin
         push(K_TOUT, 0, t_o + TO);
         wait_cyc(TO + 1);
      end else begin
         wait_cyc(k);
         send_rx(pid, err);
         push((pid == 3'd0 && !err) ? K_DONE : K_ERR, 0, cyc);
      end
      wait_cyc(2);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, queue depth %0d", exp_q.size());
      $fatal(1, "watchdog");
   end

   initial begin
      int kind, occ;
      logic [2:0] resp;
      wait_cyc(3);
      chk("reset_state", int'(ctrl_state), 0);
      chk("reset_d_mode", int'(d_mode), 0);
      chk("reset_tx_packet", int'(tx_packet), 0);
      chk("reset_pulses", int'({xfer_err, timeout, xfer_done, tx_start, clear_tx_control}), 0);
      n_rst = 1'b1;
      wait_cyc(1);

      in_xact(3, 1, 8, 5, 1'b0, 1, 3'd3);  // DATA, ACK; ctrl on last legal cycle
      in_xact(0, 1, 0, 3, 1'b0, 0, 3'd0);  // empty buffer -> NAK, no handshake
      in_xact(0, 0, 8, 1, 1'b0, 0, 3'd0);  // software never answers
      out_xact(1, 3'd0, 1'b1);
      out_xact(1, 3'd0, 1'b0);
      out_xact(3, 3'd0, 1'b0);             // packet on the expiry cycle wins
      out_xact(TO, 3'd0, 1'b0);
      in_xact(1, 1, 8, 3, 1'b1, 0, 3'd0);  // tx_error as active falls
      in_xact(2, 2, 8, 2, 1'b0, 0, 3'd0);
      in_xact(0, 1, 9, 2, 1'b0, 1, 3'd4);
      in_xact(0, 1, 9, 2, 1'b0, TO, 3'd0);
      in_xact(TO, 3, 8, 1, 1'b0, 0, 3'd0);

      // Stray handshake/data packets in IDLE are ignored.
      send_rx(3'd3, 1'b0);
      send_rx(3'd0, 1'b0);
      wait_cyc(1);
      chk("idle_ignores_packets", int'(ctrl_state), 0);

      // Reset while transmitting abandons the transaction silently.
      send_rx(3'd1, 1'b0);
      tx_ctrl = 2'd1;
      buffer_occupancy = 7'd8;
      wait_cyc(1);
      tx_ctrl = '0;
      push(K_START, 1, cyc);
      wait_cyc(1);
      tx_transfer_active = 1'b1;
      wait_cyc(2);
      chk("busy_state", int'(ctrl_state), 3);
      chk("busy_d_mode", int'(d_mode), 1);
      n_rst = 1'b0;
      wait_cyc(1);
      n_rst = 1'b1;
      tx_transfer_active = 1'b0;
      chk("rst_mid_state", int'(ctrl_state), 0);
      chk("rst_mid_d_mode", int'(d_mode), 0);
      chk("rst_mid_tx_packet", int'(tx_packet), 0);
      chk("rst_mid_pulses", int'({xfer_err, timeout, xfer_done, tx_start}), 0);
      wait_cyc(TO + 2);

      for (int n = 0; n < 40; n++) begin
         kind = int'($urandom_range(0, 1));
         occ  = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 127));
         case ($urandom_range(0, 3))
            0:       resp = 3'd3;
            1:       resp = 3'd4;
            default: resp = 3'($urandom_range(0, 7));
         endcase
         if (kind == 0) begin
            in_xact(int'($urandom_range(0, TO + 1)), int'($urandom_range(0, 3)), occ,
                    int'($urandom_range(1, 5)), ($urandom_range(0, 3) == 0),
                    int'($urandom_range(0, TO + 1)), resp);
         end else begin
            out_xact(int'($urandom_range(0, TO + 1)),
                     ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(3, 7)),
                     ($urandom_range(0, 3) == 0));
         end
      end

      wait_cyc(2);
      chk("queue_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
